// File: rtl/branch_hazard_ctrl_if.sv
// Signal bundle between the ID-stage branch sequencing controller and its neighbours:
// the decoder, the pipeline registers, the branch unit, the PC/IF_ID and the statistics readers.
interface branch_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [6:0]       id_opcode;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic             mem_mem_read;
    logic [4:0]       wb_rd;
    logic             wb_reg_write;
    logic             branch_flag;
    logic             icache_ready;

    logic [1:0]       select1;
    logic [1:0]       select2;
    logic             pc_stall;
    logic             ifid_stall;
    logic             idex_bubble;
    logic             pc_sel_branch;
    logic             ifid_flush;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_taken;
    logic [CNT_W-1:0] stat_stall_cycles;
    logic             stall_err;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2,
        output ex_rd, ex_reg_write, ex_mem_read,
        output mem_rd, mem_reg_write, mem_mem_read,
        output wb_rd, wb_reg_write, branch_flag, icache_ready,
        input  select1, select2, pc_stall, ifid_stall, idex_bubble,
        input  pc_sel_branch, ifid_flush,
        input  stat_branches, stat_taken, stat_stall_cycles, stall_err
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2,
        input  ex_rd, ex_reg_write, ex_mem_read,
        input  mem_rd, mem_reg_write, mem_mem_read,
        input  wb_rd, wb_reg_write, branch_flag, icache_ready,
        output select1, select2, pc_stall, ifid_stall, idex_bubble,
        output pc_sel_branch, ifid_flush,
        output stat_branches, stat_taken, stat_stall_cycles, stall_err
    );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch sequencing: operand forwarding selects, RAW stall, taken-branch redirect/flush
// with icache refill wait, saturating branch statistics and a sticky stall watchdog.
module branch_hazard_ctrl #(
    parameter int MAX_STALL = 3,
    parameter int CNT_W     = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    branch_hazard_ctrl_if.slave bus
);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam int RUN_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] MAX_RUN = RUN_W'(MAX_STALL);

    typedef enum logic [1:0] {RUN, STALL, REFILL} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] branches_q;
    logic [CNT_W-1:0] taken_q;
    logic [CNT_W-1:0] stall_cycles_q;
    logic [RUN_W-1:0] run_cnt;
    logic             stall_err_q;

    logic id_live;
    logic is_br;
    logic hazard;
    logic resolved;
    logic taken;

    function automatic logic src_hazard(input logic [4:0] r, input logic [4:0] ex_rd,
                                        input logic [4:0] mem_rd, input logic ex_rw,
                                        input logic mem_mr);
        return (r != 5'd0) && ((ex_rw && ex_rd == r) || (mem_mr && mem_rd == r));
    endfunction

    // An ALU result in ALU_MEM wins over MEM_WB because it is the younger write.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic [4:0] mem_rd,
                                           input logic [4:0] wb_rd, input logic mem_rw,
                                           input logic mem_mr, input logic wb_rw);
        if (r == 5'd0)                          return 2'b00;
        if (mem_rw && !mem_mr && mem_rd == r)   return 2'b01;
        if (wb_rw && wb_rd == r)                return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The decode stage is not looked at while waiting for the refill.
    assign id_live  = (state != REFILL);
    assign is_br    = bus.id_valid && (bus.id_opcode == OP_BRANCH);
    assign hazard   = id_live && is_br &&
                      (src_hazard(bus.id_rs1, bus.ex_rd, bus.mem_rd, bus.ex_reg_write, bus.mem_mem_read) ||
                       src_hazard(bus.id_rs2, bus.ex_rd, bus.mem_rd, bus.ex_reg_write, bus.mem_mem_read));
    assign resolved = id_live && is_br && !hazard;
    assign taken    = resolved && bus.branch_flag;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        bus.select1       = 2'b00;
        bus.select2       = 2'b00;
        bus.pc_stall      = 1'b0;
        bus.ifid_stall    = 1'b0;
        bus.idex_bubble   = 1'b0;
        bus.pc_sel_branch = 1'b0;
        bus.ifid_flush    = 1'b0;
        state_nxt         = state;

        if (rst_n) begin
            if (id_live && is_br) begin
                bus.select1 = fwd_sel(bus.id_rs1, bus.mem_rd, bus.wb_rd,
                                      bus.mem_reg_write, bus.mem_mem_read, bus.wb_reg_write);
                bus.select2 = fwd_sel(bus.id_rs2, bus.mem_rd, bus.wb_rd,
                                      bus.mem_reg_write, bus.mem_mem_read, bus.wb_reg_write);
            end

            case (state)
                RUN, STALL: begin
                    if (hazard) begin
                        bus.pc_stall    = 1'b1;
                        bus.ifid_stall  = 1'b1;
                        bus.idex_bubble = 1'b1;
                        state_nxt       = STALL;
                    end else if (taken) begin
                        bus.pc_sel_branch = 1'b1;
                        bus.ifid_flush    = 1'b1;
                        state_nxt         = bus.icache_ready ? RUN : REFILL;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                REFILL: begin
                    if (!bus.icache_ready) begin
                        bus.pc_stall   = 1'b1;
                        bus.ifid_flush = 1'b1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            branches_q     <= '0;
            taken_q        <= '0;
            stall_cycles_q <= '0;
            run_cnt        <= '0;
            stall_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here samples the pre-edge values.
            state <= state_nxt;
            if (resolved) branches_q <= sat_inc(branches_q);
            if (taken)    taken_q    <= sat_inc(taken_q);
            if (hazard) begin
                stall_cycles_q <= sat_inc(stall_cycles_q);
                // A further hazard once MAX_STALL cycles are already counted makes the run too long.
                if (run_cnt == MAX_RUN) stall_err_q <= 1'b1;
                else                    run_cnt     <= run_cnt + RUN_W'(1);
            end else begin
                run_cnt <= '0;
            end
        end
    end

    assign bus.stat_branches     = branches_q;
    assign bus.stat_taken        = taken_q;
    assign bus.stat_stall_cycles = stall_cycles_q;
    assign bus.stall_err         = stall_err_q;
endmodule

// File: doc/branch_hazard_ctrl.md
# branch_hazard_ctrl

Sequencing controller for the ID-stage branch unit. It drives the branch unit's two forwarding selects, stalls the front end while a branch operand is still being produced, and applies the redirect/flush sequence on a taken branch, including waiting out an instruction-cache refill. It also keeps saturating branch statistics and a sticky stall-watchdog error. It sits between the decoder, the ID_EX / ALU_MEM / MEM_WB pipeline registers, the branch unit and the PC / IF_ID registers.

## Interface
- MAX_STALL, 3: a stall run longer than this many consecutive cycles sets `stall_err`.
- CNT_W, 16: width of the statistics counters.

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  IF_ID holds a valid instruction
- id_opcode  in  7  decoded opcode; B-type branch = 7'b1100011
- id_rs1, id_rs2  in  5 each  branch source registers
- ex_rd, ex_reg_write, ex_mem_read  in  5/1/1  instruction in ID_EX
- mem_rd, mem_reg_write, mem_mem_read  in  5/1/1  instruction in ALU_MEM
- wb_rd, wb_reg_write  in  5/1  instruction in MEM_WB
- branch_flag  in  1  branch unit's taken result, combinational
- icache_ready  in  1  instruction cache delivers the fetch for the current PC this cycle
- select1, select2  out  2 each  forwarding mux selects to the branch unit: 00 = register, 01 = ALU_MEM, 10 = MEM_WB
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF_ID
- idex_bubble  out  1  load a NOP into ID_EX
- pc_sel_branch  out  1  PC loads the branch address at this edge
- ifid_flush  out  1  load a NOP into IF_ID
- stat_branches, stat_taken, stat_stall_cycles  out  CNT_W each  saturating counters
- stall_err  out  1  sticky watchdog flag

## Operation
- `is_br` = `id_valid` && `id_opcode` == 1100011. For register r ∈ {rs1, rs2} with r != 0:
  - `haz_ex`: `ex_reg_write` && `ex_rd` == r.
  - `haz_ld`: `mem_mem_read` && `mem_rd` == r.
  - `hazard` = `is_br` && (`haz_ex` || `haz_ld`) on either source.
- Select per operand, in priority order:
  - 01 if `mem_reg_write` && !`mem_mem_read` && `mem_rd` == r != 0;
  - else 10 if `wb_reg_write` && `wb_rd` == r != 0;
  - else 00.
  - Selects are 00 when !`is_br`.
- States are RUN, STALL and REFILL. All control outputs are combinational from state and inputs; counters and state are registered.
- RUN / STALL:
  - If `hazard`: `pc_stall` = `ifid_stall` = `idex_bubble` = 1 and the next state is STALL. The branch result is ignored, because `hazard` has priority over `branch_flag`.
  - Else if `is_br` && `branch_flag`: `pc_sel_branch` = `ifid_flush` = 1. The next state is RUN if `icache_ready`, else REFILL.
  - Else the next state is RUN.
- REFILL: `pc_stall` = 1 and `ifid_flush` = 1 while !`icache_ready`. When `icache_ready` = 1, no flush is asserted and the next state is RUN. ID-side inputs are ignored in REFILL.
- Counters, saturating at all ones:
  - `stat_branches` increments on each resolved branch (`is_br` && !`hazard`, in RUN/STALL).
  - `stat_taken` increments on resolved branches that are taken.
  - `stat_stall_cycles` increments on every cycle with `hazard`.
- Watchdog:
  - An internal run counter increments on each `hazard` cycle and clears on any non-hazard cycle.
  - `stall_err` sets when the run counter exceeds MAX_STALL. It clears only on reset.

## Timing
- Reset (asynchronous, `rst_n` = 0): state RUN; all counters 0; `stall_err` 0. All outputs read 0 while `rst_n` = 0, regardless of inputs.
- Branch with no hazard resolves in the same cycle it is in ID. The PC redirect and the flush take effect at that edge, giving a taken penalty of 1 cycle plus any REFILL cycles.
- ALU producer in ID_EX: 1 stall cycle.
- Load producer:
  - In ID_EX: 2 stall cycles (ex hazard, then ld hazard).
  - In ALU_MEM: 1 stall cycle.
- The branch resolves in the cycle `hazard` first drops. The FSM is in STALL at that point and follows the RUN rules.
- Back-to-back branches: a not-taken branch followed immediately by another branch needs no extra cycles.
- Reset asserted in STALL or REFILL returns the block to RUN immediately, with no flush or redirect.

## Test plan
- Forwarding: BEQ x5, x6 with `mem_rd` = 5 (ALU result) and `wb_rd` = 6, no hazards, `branch_flag` = 1 -> `select1` = 01, `select2` = 10, `pc_sel_branch` = `ifid_flush` = 1 for 1 cycle, `stat_taken` = 1.
- ALU producer: BNE x3 with `ex_rd` = 3 (ALU op) -> 1 cycle of `pc_stall`/`ifid_stall`/`idex_bubble`, with `branch_flag` = 1 ignored during it. Next cycle `select1` = 01 and the branch resolves. `stat_stall_cycles` = 1.
- Load producer: load-use on x7 with a load in ID_EX -> 2 stall cycles, then `select` = 10 and resolve. With MAX_STALL = 1, `stall_err` = 1 and stays 1.
- Refill: taken branch with `icache_ready` = 0 for 3 cycles -> REFILL, with `ifid_flush` and `pc_stall` held 3 cycles, then RUN on the cycle `icache_ready` = 1.
- Reset and edge cases: `rst_n` pulsed low mid-REFILL -> RUN and all outputs 0 at once. A branch whose source is x0 and matches `ex_rd` = 0 -> no stall.
- Saturation: force 2^CNT_W+5 resolved branches -> `stat_branches` = 16'hFFFF.
